// File: rtl/alu_pkg.sv
`default_nettype none
//==============================================================================
// Module      : alu_pkg
// Description : Shared opcode encoding and default sizes for the ALU pipeline.
// Revision    : 1.0 - initial release
//==============================================================================
package alu_pkg;

    // Default datapath and opcode-select widths
    localparam int ALU_WIDTH_DEF = 8;
    localparam int ALU_OPW_DEF   = 6;

    // Opcode set. Values are plain integers so that the decoder can compare
    // against a zero-extended select of any width OPW up to 32.
    localparam int unsigned OP_LDA   = 32'h00;
    localparam int unsigned OP_LDB   = 32'h01;
    localparam int unsigned OP_LDCA  = 32'h02;
    localparam int unsigned OP_LDCB  = 32'h03;
    localparam int unsigned OP_STA   = 32'h04;
    localparam int unsigned OP_STB   = 32'h05;
    localparam int unsigned OP_ADDA  = 32'h06;
    localparam int unsigned OP_ADDB  = 32'h07;
    localparam int unsigned OP_ADDCA = 32'h08;
    localparam int unsigned OP_ADDCB = 32'h09;
    localparam int unsigned OP_SUBA  = 32'h0A;
    localparam int unsigned OP_SUBB  = 32'h0B;
    localparam int unsigned OP_SUBCA = 32'h0C;
    localparam int unsigned OP_SUBCB = 32'h0D;
    localparam int unsigned OP_ANDA  = 32'h0E;
    localparam int unsigned OP_ANDB  = 32'h0F;
    localparam int unsigned OP_ANDCA = 32'h10;
    localparam int unsigned OP_ANDCB = 32'h11;
    localparam int unsigned OP_ORA   = 32'h12;
    localparam int unsigned OP_ORB   = 32'h13;
    localparam int unsigned OP_ORCA  = 32'h14;
    localparam int unsigned OP_ORCB  = 32'h15;
    localparam int unsigned OP_ASLA  = 32'h16;
    localparam int unsigned OP_ASRA  = 32'h17;
    localparam int unsigned OP_JMP   = 32'h18;
    localparam int unsigned OP_BAEQ  = 32'h19;
    localparam int unsigned OP_BANE  = 32'h1A;
    localparam int unsigned OP_BACS  = 32'h1B;
    localparam int unsigned OP_BACC  = 32'h1C;
    localparam int unsigned OP_BAMI  = 32'h1D;
    localparam int unsigned OP_BAPL  = 32'h1E;
    localparam int unsigned OP_BBEQ  = 32'h1F;
    localparam int unsigned OP_BBNE  = 32'h20;
    localparam int unsigned OP_BBCS  = 32'h21;
    localparam int unsigned OP_BBCC  = 32'h22;
    localparam int unsigned OP_BBMI  = 32'h23;
    localparam int unsigned OP_BBPL  = 32'h24;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_comb.sv
`default_nettype none
//==============================================================================
// Module      : alu_comb
// Description : Purely combinational ALU core: next result, carry/borrow
//               outputs with their write enables, and branch condition.
// Revision    : 1.0 - initial release
//==============================================================================
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEF,
    parameter int OPW   = ALU_OPW_DEF
) (
    input  logic [OPW-1:0]   i_op,
    input  logic [WIDTH-1:0] i_oper1,
    input  logic [WIDTH-1:0] i_oper2,
    input  logic             i_bca,
    input  logic             i_bcb,
    output logic [WIDTH-1:0] o_data,
    output logic             o_bca_we,
    output logic             o_bca,
    output logic             o_bcb_we,
    output logic             o_bcb,
    output logic             o_branch
);

    // Extended-width arithmetic: the top bit is the carry (add) or borrow (sub)
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_dif12;
    logic [WIDTH:0] w_dif21;
    logic           w_msb1;
    logic           w_is_zero1;

    assign w_sum      = {1'b0, i_oper1} + {1'b0, i_oper2};
    assign w_dif12    = {1'b0, i_oper1} - {1'b0, i_oper2};
    assign w_dif21    = {1'b0, i_oper2} - {1'b0, i_oper1};
    assign w_msb1     = i_oper1[WIDTH-1];
    assign w_is_zero1 = (i_oper1 == '0);

    // Opcode decode; branch results are the condition zero-extended to WIDTH
    always_comb begin
        o_data   = '0;
        o_bca_we = 1'b0;
        o_bca    = 1'b0;
        o_bcb_we = 1'b0;
        o_bcb    = 1'b0;
        o_branch = 1'b0;
        case (32'(i_op))
            OP_LDA, OP_LDB, OP_LDCA, OP_LDCB: o_data = i_oper2;
            OP_STA, OP_STB:                   o_data = i_oper1;
            OP_ADDA, OP_ADDCA: begin
                o_data   = w_sum[WIDTH-1:0];
                o_bca_we = 1'b1;
                o_bca    = w_sum[WIDTH];
            end
            OP_ADDB, OP_ADDCB: begin
                o_data   = w_sum[WIDTH-1:0];
                o_bcb_we = 1'b1;
                o_bcb    = w_sum[WIDTH];
            end
            OP_SUBA, OP_SUBCA: begin
                o_data   = w_dif12[WIDTH-1:0];
                o_bca_we = 1'b1;
                o_bca    = w_dif12[WIDTH];
            end
            OP_SUBB, OP_SUBCB: begin
                o_data   = w_dif21[WIDTH-1:0];
                o_bcb_we = 1'b1;
                o_bcb    = w_dif21[WIDTH];
            end
            OP_ANDA, OP_ANDB, OP_ANDCA, OP_ANDCB: o_data = i_oper1 & i_oper2;
            OP_ORA, OP_ORB, OP_ORCA, OP_ORCB:     o_data = i_oper1 | i_oper2;
            OP_ASLA: begin
                o_data   = {i_oper1[WIDTH-2:0], 1'b0};
                o_bca_we = 1'b1;
                o_bca    = w_msb1;
            end
            OP_ASRA: begin
                o_data   = {w_msb1, i_oper1[WIDTH-1:1]};
                o_bca_we = 1'b1;
                o_bca    = i_oper1[0];
            end
            OP_JMP:             o_branch = 1'b1;
            OP_BAEQ, OP_BBEQ: begin o_branch = w_is_zero1;  o_data = WIDTH'(w_is_zero1);  end
            OP_BANE, OP_BBNE: begin o_branch = !w_is_zero1; o_data = WIDTH'(!w_is_zero1); end
            OP_BAMI, OP_BBMI: begin o_branch = w_msb1;      o_data = WIDTH'(w_msb1);      end
            OP_BAPL, OP_BBPL: begin o_branch = !w_msb1;     o_data = WIDTH'(!w_msb1);     end
            OP_BACS:          begin o_branch = i_bca;       o_data = WIDTH'(i_bca);       end
            OP_BACC:          begin o_branch = !i_bca;      o_data = WIDTH'(!i_bca);      end
            OP_BBCS:          begin o_branch = i_bcb;       o_data = WIDTH'(i_bcb);       end
            OP_BBCC:          begin o_branch = !i_bcb;      o_data = WIDTH'(!i_bcb);      end
            default:            o_data = '0;
        endcase
    end

endmodule : alu_comb
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
//==============================================================================
// Module      : alu_pipe
// Description : Single-stage ALU with valid/ready handshake, registered
//               result/status outputs and architectural carry flags A/B.
// Revision    : 1.0 - initial release
//==============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEF,
    parameter int OPW   = ALU_OPW_DEF
) (
    input  logic             iClock,
    input  logic             iReset,
    input  logic             iValid,
    output logic             oReady,
    input  logic [OPW-1:0]   iAluInstSel,
    input  logic [WIDTH-1:0] iAluOper1,
    input  logic [WIDTH-1:0] iAluOper2,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oAluData,
    output logic             oZero,
    output logic             oNeg,
    output logic             oBCA,
    output logic             oBCB,
    output logic             oBranchTaken
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_zero;
    logic             r_neg;
    logic             r_branch;
    logic             r_bca;
    logic             r_bcb;

    logic [WIDTH-1:0] w_data;
    logic             w_bca_we;
    logic             w_bca;
    logic             w_bcb_we;
    logic             w_bcb;
    logic             w_branch;
    logic             w_accept;

    // The output slot frees up when empty or when the current result is taken
    assign oReady   = !r_valid || iReady;
    assign w_accept = iValid && oReady;

    // Branches read the committed flags, so the previous accept is visible
    alu_comb #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_alu_comb (
        .i_op     (iAluInstSel),
        .i_oper1  (iAluOper1),
        .i_oper2  (iAluOper2),
        .i_bca    (r_bca),
        .i_bcb    (r_bcb),
        .o_data   (w_data),
        .o_bca_we (w_bca_we),
        .o_bca    (w_bca),
        .o_bcb_we (w_bcb_we),
        .o_bcb    (w_bcb),
        .o_branch (w_branch)
    );

    // Result and flag registers: load on accept, drain when taken, else hold
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_branch <= 1'b0;
            r_bca    <= 1'b0;
            r_bcb    <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_data   <= w_data;
            r_zero   <= (w_data == '0);
            r_neg    <= w_data[WIDTH-1];
            r_branch <= w_branch;
            if (w_bca_we) r_bca <= w_bca;
            if (w_bcb_we) r_bcb <= w_bcb;
        end else if (iReady) begin
            r_valid  <= 1'b0;
        end
    end

    assign oValid       = r_valid;
    assign oAluData     = r_data;
    assign oZero        = r_zero;
    assign oNeg         = r_neg;
    assign oBranchTaken = r_branch;
    assign oBCA         = r_bca;
    assign oBCB         = r_bcb;

endmodule : alu_pipe
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
//==============================================================================
// Module      : tb_alu_pipe
// Description : Self-checking bench for alu_pipe (WIDTH=8) with a result
//               scoreboard and directed handshake/reset checks.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int WIDTH = 8;
    localparam int OPW   = 6;

    typedef struct packed {
        logic [7:0] data;
        logic       zero;
        logic       neg;
        logic       bca;
        logic       bcb;
        logic       br;
    } exp_t;

    logic             iClock = 1'b0;
    logic             iReset;
    logic             iValid;
    logic             oReady;
    logic [OPW-1:0]   iAluInstSel;
    logic [WIDTH-1:0] iAluOper1;
    logic [WIDTH-1:0] iAluOper2;
    logic             oValid;
    logic             iReady;
    logic [WIDTH-1:0] oAluData;
    logic             oZero;
    logic             oNeg;
    logic             oBCA;
    logic             oBCB;
    logic             oBranchTaken;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    logic m_bca = 1'b0;
    logic m_bcb = 1'b0;

    alu_pipe #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .iClock       (iClock),
        .iReset       (iReset),
        .iValid       (iValid),
        .oReady       (oReady),
        .iAluInstSel  (iAluInstSel),
        .iAluOper1    (iAluOper1),
        .iAluOper2    (iAluOper2),
        .oValid       (oValid),
        .iReady       (iReady),
        .oAluData     (oAluData),
        .oZero        (oZero),
        .oNeg         (oNeg),
        .oBCA         (oBCA),
        .oBCB         (oBCB),
        .oBranchTaken (oBranchTaken)
    );

    always #5 iClock = ~iClock;

    // Reference model of one accepted instruction; updates the model flags
    task automatic model(input int op, input logic [7:0] a, input logic [7:0] b, output exp_t e);
        int   ua = int'(a);
        int   ub = int'(b);
        logic c  = 1'b0;
        e = '0;
        case (op)
            OP_LDA, OP_LDB, OP_LDCA, OP_LDCB: e.data = b;
            OP_STA, OP_STB:                   e.data = a;
            OP_ADDA, OP_ADDCA: begin e.data = 8'(ua + ub); m_bca = (ua + ub) > 255; end
            OP_ADDB, OP_ADDCB: begin e.data = 8'(ua + ub); m_bcb = (ua + ub) > 255; end
            OP_SUBA, OP_SUBCA: begin e.data = 8'(ua - ub); m_bca = (ua < ub); end
            OP_SUBB, OP_SUBCB: begin e.data = 8'(ub - ua); m_bcb = (ub < ua); end
            OP_ANDA, OP_ANDB, OP_ANDCA, OP_ANDCB: e.data = a & b;
            OP_ORA, OP_ORB, OP_ORCA, OP_ORCB:     e.data = a | b;
            OP_ASLA: begin e.data = 8'(ua * 2); m_bca = (ua >= 128); end
            OP_ASRA: begin e.data = 8'((ua / 2) + (ua & 128)); m_bca = (ua % 2) == 1; end
            OP_JMP:  e.br = 1'b1;
            OP_BAEQ, OP_BBEQ, OP_BANE, OP_BBNE, OP_BAMI, OP_BBMI,
            OP_BAPL, OP_BBPL, OP_BACS, OP_BACC, OP_BBCS, OP_BBCC: begin
                case (op)
                    OP_BAEQ, OP_BBEQ: c = (ua == 0);
                    OP_BANE, OP_BBNE: c = (ua != 0);
                    OP_BAMI, OP_BBMI: c = (ua >= 128);
                    OP_BAPL, OP_BBPL: c = (ua < 128);
                    OP_BACS:          c = m_bca;
                    OP_BACC:          c = !m_bca;
                    OP_BBCS:          c = m_bcb;
                    default:          c = !m_bcb;
                endcase
                e.data = c ? 8'd1 : 8'd0;
                e.br   = c;
            end
            default: e.data = 8'h00;
        endcase
        e.zero = (e.data == 8'h00);
        e.neg  = e.data[7];
        e.bca  = m_bca;
        e.bcb  = m_bcb;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one instruction from a falling edge; returns on the falling edge after accept
    task automatic send(input int op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   n = 0;
        iAluInstSel = 6'(op);
        iAluOper1   = a;
        iAluOper2   = b;
        iValid      = 1'b1;
        while (!oReady && n < 20) begin
            @(negedge iClock);
            n++;
        end
        if (!oReady) begin
            n_tests++;
            n_fail++;
            $error("FAIL send_timeout: observed oReady 0 expected 1 within 20 cycles (op %0h)", op);
            iValid = 1'b0;
        end else begin
            model(op, a, b, e);
            sb.push_back(e);
            @(negedge iClock);
            iValid = 1'b0;
        end
    endtask

    // Scoreboard: compare every result at the cycle it is handed downstream
    always @(negedge iClock) begin
        if (!iReset && oValid && iReady) begin
            n_tests++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_result: observed data %0h expected no result", oAluData);
            end
            if (sb.size() != 0) begin
                exp_t e;
                exp_t o;
                e = sb.pop_front();
                o = {oAluData, oZero, oNeg, oBCA, oBCB, oBranchTaken};
                n_tests++;
                assert (o === e) else begin
                    n_fail++;
                    $error("FAIL result: observed d=%h z%b n%b bca%b bcb%b br%b expected d=%h z%b n%b bca%b bcb%b br%b",
                           o.data, o.zero, o.neg, o.bca, o.bcb, o.br,
                           e.data, e.zero, e.neg, e.bca, e.bcb, e.br);
                end
            end
        end
    end

    initial begin
        iReset = 1'b1; iValid = 1'b0; iReady = 1'b1;
        iAluInstSel = '0; iAluOper1 = '0; iAluOper2 = '0;
        repeat (2) @(negedge iClock);
        check("rst_valid", 32'(oValid), 0);
        check("rst_data",  32'(oAluData), 0);
        check("rst_flags", {27'd0, oZero, oNeg, oBCA, oBCB, oBranchTaken}, 0);
        check("rst_ready", 32'(oReady), 1);
        iReset = 1'b0;

        // Core arithmetic, logic, load/store and branch patterns
        send(OP_ADDA, 8'hF0, 8'h20);
        check("valid_latency", 32'(oValid), 1);
        send(OP_SUBB, 8'h05, 8'h03);
        send(OP_ASLA, 8'h81, 8'h00);
        send(OP_ASRA, 8'h81, 8'h00);
        send(OP_SUBA, 8'h05, 8'h03);
        send(OP_ADDA, 8'hFF, 8'h01);
        send(OP_BACS, 8'h00, 8'h00);
        send(OP_BACC, 8'h00, 8'h00);
        send(OP_ANDA, 8'hF0, 8'h3C);
        send(OP_ORB,  8'h0F, 8'h30);
        send(OP_LDA,  8'h12, 8'h34);
        send(OP_STB,  8'h12, 8'h34);
        send(OP_JMP,  8'h55, 8'h66);
        send(32'h30,  8'hAA, 8'hBB);
        send(OP_BAEQ, 8'h00, 8'h00);
        send(OP_BANE, 8'h00, 8'h00);
        send(OP_BAMI, 8'h80, 8'h00);
        send(OP_BAPL, 8'h80, 8'h00);
        send(OP_BBPL, 8'h7F, 8'h00);
        send(OP_BBCS, 8'h00, 8'h00);
        send(OP_BBCC, 8'h00, 8'h00);
        send(OP_SUBCB, 8'h03, 8'h05);
        send(OP_BBCC, 8'h00, 8'h00);
        send(OP_ADDCB, 8'h80, 8'h80);

        // Backpressure: hold a result for three cycles with a new request waiting
        @(posedge iClock); #2 iReady = 1'b0;
        @(negedge iClock);
        send(OP_LDA, 8'h00, 8'h5A);
        iAluInstSel = 6'(OP_ADDA); iAluOper1 = 8'h11; iAluOper2 = 8'h22; iValid = 1'b1;
        repeat (3) begin
            check("stall_ready", 32'(oReady), 0);
            check("stall_hold",  {23'd0, oValid, oAluData}, {23'd0, 1'b1, 8'h5A});
            @(negedge iClock);
        end
        @(posedge iClock); #2 iReady = 1'b1;
        begin
            exp_t e;
            model(OP_ADDA, 8'h11, 8'h22, e);
            sb.push_back(e);
        end
        @(posedge iClock); #2 iValid = 1'b0;
        @(negedge iClock);
        @(negedge iClock);
        check("one_accept", 32'(oValid), 0);
        check("sb_drained", 32'(sb.size()), 0);

        // Reset while a result is stalled, with both carry flags set
        send(OP_ADDA, 8'hF0, 8'h20);
        send(OP_ADDB, 8'hF0, 8'h20);
        @(posedge iClock); #2 iReady = 1'b0;
        @(negedge iClock);
        send(OP_LDB, 8'h00, 8'h77);
        check("pre_rst_flags", {30'd0, oBCA, oBCB}, 3);
        @(posedge iClock); #2 iReset = 1'b1;
        #1;
        check("async_rst_data", {23'd0, oValid, oAluData}, 0);
        check("async_rst_flags", {27'd0, oZero, oNeg, oBCA, oBCB, oBranchTaken}, 0);
        sb.delete();
        m_bca = 1'b0;
        m_bcb = 1'b0;
        @(negedge iClock);
        iReady = 1'b1;
        iReset = 1'b0;
        #1;
        check("post_rst_ready", 32'(oReady), 1);
        @(negedge iClock);
        check("post_rst_flags", {29'd0, oValid, oBCA, oBCB}, 0);
        send(OP_BACS, 8'h00, 8'h00);
        @(negedge iClock);
        @(negedge iClock);
        check("sb_final", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_pipe
`default_nettype wire
